// File: rtl/data_mem_responder_if.sv
// Data-memory port between the CPU core (master) and the memory responder
// (slave). Carries the request, store data, load data, stall and error status.
interface data_mem_responder_if;
  logic [31:0] memAddr;
  logic [31:0] memDataWrite;
  logic        memRead;
  logic        memWrite;
  logic [31:0] memDataRead;
  logic        memStall;
  logic        memError;
  logic [7:0]  errCount;

  modport master (
    output memAddr, memDataWrite, memRead, memWrite,
    input  memDataRead, memStall, memError, errCount
  );

  modport slave (
    input  memAddr, memDataWrite, memRead, memWrite,
    output memDataRead, memStall, memError, errCount
  );
endinterface

// File: rtl/data_mem_responder.sv
// Responder end of the core's data-memory port. A request seen in IDLE is
// latched, held for WAIT_STATES cycles, and committed on the edge into DONE.
// The core is stalled while the access is in flight. Illegal accesses
// (misaligned, below base, beyond the RAM, or read+write together) keep the
// full timing, leave the RAM alone, pulse memError and bump a saturating count.
module data_mem_responder #(
  parameter int          DEPTH_WORDS = 256,
  parameter int          WAIT_STATES = 2,
  parameter logic [31:0] ADDR_BASE   = 32'h0000_0000
) (
  input  logic                 clock__i,
  input  logic                 reset_n__i,
  data_mem_responder_if.slave  bus
);

  localparam int AW      = $clog2(DEPTH_WORDS);
  localparam bit NO_WAIT = (WAIT_STATES == 0);

  typedef enum logic [1:0] {
    IDLE,
    WAIT,
    DONE
  } state_t;

  state_t      state;
  logic [3:0]  wait_cnt;

  // Request captured in IDLE; only these are used once the access is running.
  logic [31:0] lat_addr;
  logic [31:0] lat_wdata;
  logic        lat_rd;
  logic        lat_wr;

  // Registered outputs.
  logic [31:0] rdata_q;
  logic        err_q;
  logic [7:0]  err_cnt_q;

  logic [31:0] mem [DEPTH_WORDS];

  // The access being evaluated: the live bus in IDLE (needed when there are
  // no wait states and the commit edge is the capture edge), latched otherwise.
  logic [31:0] cur_addr;
  logic [31:0] cur_wdata;
  logic        cur_rd;
  logic        cur_wr;

  logic        req;
  logic [32:0] offset_ext;
  logic        below_base;
  logic        misaligned;
  logic        out_of_range;
  logic        conflict;
  logic        illegal;
  logic [AW-1:0] idx;
  logic        enter_done;

  assign req = bus.memRead | bus.memWrite;

  // Select live or latched request fields.
  // NOTE: every signal assigned in always_comb gets a default first, so no path leaves it unassigned and no latch is inferred.
  always_comb begin
    cur_addr  = lat_addr;
    cur_wdata = lat_wdata;
    cur_rd    = lat_rd;
    cur_wr    = lat_wr;
    if (state == IDLE) begin
      cur_addr  = bus.memAddr;
      cur_wdata = bus.memDataWrite;
      cur_rd    = bus.memRead;
      cur_wr    = bus.memWrite;
    end
  end

  // The borrow out of the 33-bit subtraction flags an address below the base;
  // since the base is word-aligned the low offset bits give alignment directly.
  assign offset_ext   = {1'b0, cur_addr} - {1'b0, ADDR_BASE};
  assign below_base   = offset_ext[32];
  assign misaligned   = (offset_ext[1:0] != 2'b00);
  assign out_of_range = (offset_ext[31:2] >= 30'(DEPTH_WORDS));
  assign conflict     = cur_rd & cur_wr;
  assign illegal      = below_base | misaligned | out_of_range | conflict;
  assign idx          = offset_ext[AW+1:2];

  // The edge on which the FSM enters DONE is the commit edge.
  assign enter_done = ((state == IDLE) && req && NO_WAIT) ||
                      ((state == WAIT) && (wait_cnt == 4'd1));

  // Stall is combinational so the core holds MEM in the very cycle it asks.
  assign bus.memStall    = ((state == IDLE) && req) || (state == WAIT);
  assign bus.memDataRead = rdata_q;
  assign bus.memError    = err_q;
  assign bus.errCount    = err_cnt_q;

  // Access sequencing, request capture, read data, error pulse and count.
  // NOTE: state registers use non-blocking assignment so every register samples pre-edge values and simulation matches hardware.
  always_ff @(posedge clock__i) begin
    if (!reset_n__i) begin
      state     <= IDLE;
      wait_cnt  <= 4'd0;
      lat_addr  <= 32'd0;
      lat_wdata <= 32'd0;
      lat_rd    <= 1'b0;
      lat_wr    <= 1'b0;
      rdata_q   <= 32'd0;
      err_q     <= 1'b0;
      err_cnt_q <= 8'd0;
    end else begin
      err_q <= enter_done & illegal;

      if (enter_done) begin
        if (cur_rd) begin
          rdata_q <= illegal ? 32'd0 : mem[idx];
        end
        if (illegal && (err_cnt_q != 8'hFF)) begin
          err_cnt_q <= err_cnt_q + 8'd1;
        end
      end

      case (state)
        IDLE: begin
          if (req) begin
            lat_addr  <= bus.memAddr;
            lat_wdata <= bus.memDataWrite;
            lat_rd    <= bus.memRead;
            lat_wr    <= bus.memWrite;
            wait_cnt  <= 4'(WAIT_STATES);
            state     <= NO_WAIT ? DONE : WAIT;
          end
        end
        WAIT: begin
          wait_cnt <= wait_cnt - 4'd1;
          if (wait_cnt == 4'd1) begin
            state <= DONE;
          end
        end
        DONE: begin
          // A request still visible here is the one completing; ignore it.
          state <= IDLE;
        end
        default: begin
          state <= IDLE;
        end
      endcase
    end
  end

  // Word store on the commit edge; suppressed while reset is asserted so an
  // abandoned access never lands.
  // NOTE: the RAM array has no reset; contents persist across reset and it maps onto plain memory.
  always_ff @(posedge clock__i) begin
    if (reset_n__i && enter_done && cur_wr && !illegal) begin
      mem[idx] <= cur_wdata;
    end
  end

endmodule
